// File: rtl/spi_poll_aggregator.sv
// spi_poll_aggregator
//   Sweeps up to NCH read-only SPI sensors that share one MISO line and
//   captures one WORD_W-bit word from each selected channel. Each word is
//   buffered with its channel number in a FIFO. Buffered words stream out
//   as framed bytes on a valid/ready port:
//     header {4'hA, ch}, optional sweep-stamp byte, then the word MSB first.
//
//   Optional feature macro: SPI_POLL_AGG_TIMESTAMP_EN
//     When defined, an 8-bit sweep counter is sampled at each accepted start
//     and sent as the byte that follows the header.
//
//   Ports
//     clk, rst_n            system clock, asynchronous active-low reset
//     ena, start            start pulse, honoured only when ena is high
//     chan_mask             channels to poll (sampled at start)
//     miso                  shared sensor data
//     sclk, cs_n            SPI mode 0 clock, per-channel chip selects
//     busy                  sweep in progress
//     out_data/valid/ready  byte stream, out_last marks final frame byte
//     overflow, clear_ovf   sticky dropped-word flag and its clear
//
//   FSM states
//     state   | meaning
//     S_IDLE  | waiting for an accepted start
//     S_SETUP | cs_n low, sclk low, CLK_DIV cycles before first rise
//     S_SHIFT | WORD_W sclk periods, high half first, miso sampled at rise
//     S_HOLD  | CLK_DIV cycles after the last low half, then push the word
//     S_GAP   | CLK_DIV cycles with every cs_n high, then next channel/idle
module spi_poll_aggregator #(
  parameter int NCH        = 4,
  parameter int WORD_W     = 16,
  parameter int CLK_DIV    = 2,
  parameter int FIFO_DEPTH = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           ena,
  input  logic           start,
  input  logic [NCH-1:0] chan_mask,
  input  logic           miso,
  output logic           sclk,
  output logic [NCH-1:0] cs_n,
  output logic           busy,
  output logic [7:0]     out_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic           out_last,
  output logic           overflow,
  input  logic           clear_ovf
);

`ifdef SPI_POLL_AGG_TIMESTAMP_EN
  localparam int TS_BITS = 8;
`else
  localparam int TS_BITS = 0;
`endif
  localparam int ENTRY_W = 4 + TS_BITS + WORD_W;
  localparam int FRAME_W = 4 + ENTRY_W;
  localparam int NBYTES  = FRAME_W / 8;
  localparam int TMR_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W   = $clog2(WORD_W);
  localparam int CH_W    = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int BC_W    = $clog2(NBYTES);

  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LOAD = BIT_W'(WORD_W - 1);
  localparam logic [BC_W-1:0]  BC_LOAD  = BC_W'(NBYTES - 1);
  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SHIFT, S_HOLD, S_GAP} state_t;

  state_t             state_q, state_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic [BIT_W-1:0]   bit_q, bit_d;
  logic               ph_q, ph_d;          // 0: sclk high half, 1: low half
  logic [CH_W-1:0]    ch_q, ch_d;
  logic [NCH-1:0]     mask_q, mask_d;
  logic [WORD_W-1:0]  shreg_q;
  logic               start_acc, push_req, sample;
  logic [CH_W:0]      first_ch, next_ch;
  logic [NCH-1:0]     cs_d;
  logic [ENTRY_W-1:0] push_data;

  // Returns {found, index} of the lowest set bit of m at or above 'from'.
  function automatic logic [CH_W:0] find_ch(input logic [NCH-1:0] m, input int from);
    logic [CH_W:0] r;
    r = '0;
    for (int i = NCH - 1; i >= 0; i--)
      if (m[i] && i >= from) r = {1'b1, CH_W'(i)};
    return r;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      tmr_q   <= '0;
      bit_q   <= '0;
      ph_q    <= 1'b0;
      ch_q    <= '0;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      bit_q   <= bit_d;
      ph_q    <= ph_d;
      ch_q    <= ch_d;
      mask_q  <= mask_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    tmr_d     = tmr_q;
    bit_d     = bit_q;
    ph_d      = ph_q;
    ch_d      = ch_q;
    mask_d    = mask_q;
    start_acc = 1'b0;
    push_req  = 1'b0;
    sample    = 1'b0;
    first_ch  = find_ch(chan_mask, 0);
    next_ch   = find_ch(mask_q, int'(ch_q) + 1);
    unique case (state_q)
      S_IDLE: begin
        // busy still reads high for one cycle after GAP; starts there are ignored
        if (start && ena && !busy && (chan_mask != '0)) begin
          start_acc = 1'b1;
          mask_d    = chan_mask;
          ch_d      = first_ch[CH_W-1:0];
          tmr_d     = TMR_LOAD;
          state_d   = S_SETUP;
        end
      end
      S_SETUP: begin
        if (tmr_q == '0) begin
          tmr_d   = TMR_LOAD;
          ph_d    = 1'b0;
          bit_d   = BIT_LOAD;
          state_d = S_SHIFT;
        end else tmr_d = tmr_q - 1'b1;
      end
      S_SHIFT: begin
        // registered sclk rises at the end of the first high-half cycle
        sample = !ph_q && (tmr_q == TMR_LOAD);
        if (tmr_q == '0) begin
          tmr_d = TMR_LOAD;
          if (!ph_q) ph_d = 1'b1;
          else if (bit_q == '0) state_d = S_HOLD;
          else begin
            ph_d  = 1'b0;
            bit_d = bit_q - 1'b1;
          end
        end else tmr_d = tmr_q - 1'b1;
      end
      S_HOLD: begin
        if (tmr_q == '0) begin
          push_req = 1'b1;
          tmr_d    = TMR_LOAD;
          state_d  = S_GAP;
        end else tmr_d = tmr_q - 1'b1;
      end
      S_GAP: begin
        if (tmr_q == '0) begin
          if (next_ch[CH_W]) begin
            ch_d    = next_ch[CH_W-1:0];
            tmr_d   = TMR_LOAD;
            state_d = S_SETUP;
          end else state_d = S_IDLE;
        end else tmr_d = tmr_q - 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cs_d = '1;
    if (state_q == S_SETUP || state_q == S_SHIFT || state_q == S_HOLD)
      cs_d[ch_q] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk    <= 1'b0;
      cs_n    <= '1;
      busy    <= 1'b0;
      shreg_q <= '0;
    end else begin
      sclk <= (state_q == S_SHIFT) && !ph_q;
      cs_n <= cs_d;
      busy <= (state_q != S_IDLE);
      if (sample) shreg_q <= {shreg_q[WORD_W-2:0], miso};
    end
  end

`ifdef SPI_POLL_AGG_TIMESTAMP_EN
  logic [7:0] ts_cnt_q, ts_sweep_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts_cnt_q   <= '0;
      ts_sweep_q <= '0;
    end else if (start_acc) begin
      ts_sweep_q <= ts_cnt_q;
      ts_cnt_q   <= ts_cnt_q + 8'd1;
    end
  end
  assign push_data = {4'(ch_q), ts_sweep_q, shreg_q};
`else
  assign push_data = {4'(ch_q), shreg_q};
`endif

  // Capture FIFO; the head entry stays resident until its last byte is taken.
  logic [ENTRY_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]     cnt_q;
  logic               accept, pop, push_ok;
  logic [FRAME_W-1:0] frame_q;
  logic [BC_W-1:0]    byte_cnt_q;

  assign accept   = out_valid && out_ready;
  assign pop      = accept && (byte_cnt_q == '0);
  assign push_ok  = push_req && ((cnt_q != CNT_FULL) || pop);
  assign out_data = frame_q[FRAME_W-1 -: 8];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push_ok, pop})
        2'b10:   cnt_q <= cnt_q + (PTR_W + 1)'(1);
        2'b01:   cnt_q <= cnt_q - (PTR_W + 1)'(1);
        default: cnt_q <= cnt_q;
      endcase
      if (push_req && !push_ok) overflow <= 1'b1;
      else if (clear_ovf)       overflow <= 1'b0;
    end
  end

  // Byte serializer: frame shifted left one byte per accepted beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_q    <= '0;
      byte_cnt_q <= '0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
    end else if (!out_valid) begin
      if (cnt_q != '0) begin
        frame_q    <= {4'hA, mem[rd_ptr_q]};
        byte_cnt_q <= BC_LOAD;
        out_valid  <= 1'b1;
        out_last   <= 1'b0;
      end
    end else if (accept) begin
      if (byte_cnt_q != '0) begin
        frame_q    <= frame_q << 8;
        byte_cnt_q <= byte_cnt_q - 1'b1;
        out_last   <= (byte_cnt_q == BC_W'(1));
      end else if (cnt_q > (PTR_W + 1)'(1)) begin
        // next entry already buffered: start it without a bubble
        frame_q    <= {4'hA, mem[rd_ptr_q + PTR_W'(1)]};
        byte_cnt_q <= BC_LOAD;
        out_last   <= 1'b0;
      end else begin
        out_valid  <= 1'b0;
        out_last   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spi_poll_aggregator.sv
// Directed bench for spi_poll_aggregator (NCH=4, WORD_W=16, CLK_DIV=2, FIFO_DEPTH=8).
// Sensor model drives miso MSB first, changing after each sclk fall.
`timescale 1ns/1ps
module tb_spi_poll_aggregator;
  localparam int NCH = 4;
`ifdef SPI_POLL_AGG_TIMESTAMP_EN
  localparam int NB = 4;
`else
  localparam int NB = 3;
`endif

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           ena = 1'b1;
  logic           start = 1'b0;
  logic [NCH-1:0] chan_mask = '0;
  logic           miso = 1'b0;
  logic           sclk;
  logic [NCH-1:0] cs_n;
  logic           busy;
  logic [7:0]     out_data;
  logic           out_valid;
  logic           out_ready = 1'b1;
  logic           out_last;
  logic           overflow;
  logic           clear_ovf = 1'b0;

  spi_poll_aggregator #(.NCH(4), .WORD_W(16), .CLK_DIV(2), .FIFO_DEPTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .chan_mask(chan_mask),
    .miso(miso), .sclk(sclk), .cs_n(cs_n), .busy(busy), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .overflow(overflow), .clear_ovf(clear_ovf)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  logic [15:0]    sens [NCH];
  logic [8:0]     got_q[$];
  logic [8:0]     exp_q[$];
  int             cyc = 0;
  int             ts_model = 0;
  logic           mon_en = 1'b0;
  logic [NCH-1:0] cs_prev = '1;
  logic [NCH-1:0] ever_low = '0;
  logic           sclk_prev = 1'b0;
  int             rises = 0, fall_cyc = 0, last_rise = 0, bitpos = -1, cur_ch = 0;
  int             onehot_viol = 0, idle_viol = 0;
  int             first_acc = -1, last_acc = -1;

  // Output collector, SPI waveform monitor and sensor model, all on negedge.
  always @(negedge clk) begin
    cyc++;
    if (out_valid && out_ready) begin
      got_q.push_back({out_last, out_data});
      if (first_acc < 0) first_acc = cyc;
      last_acc = cyc;
    end
    ever_low = ever_low | ~cs_n;
    if ($countones(~cs_n) > 1) onehot_viol++;
    if (&cs_n && sclk) idle_viol++;
    if (&cs_prev && !(&cs_n)) begin
      fall_cyc = cyc;
      rises    = 0;
      bitpos   = 15;
      for (int i = 0; i < NCH; i++) if (!cs_n[i]) cur_ch = i;
    end else if (!(&cs_n) && sclk_prev && !sclk) bitpos--;
    if (sclk && !sclk_prev) begin
      rises++;
      if (mon_en) begin
        if (rises == 1) chk("first_rise", cyc - fall_cyc, 2);
        else            chk("sclk_period", cyc - last_rise, 4);
      end
      last_rise = cyc;
    end
    if (mon_en && !(&cs_prev) && &cs_n) begin
      chk("rises_per_cs", rises, 16);
      chk("cs_window", cyc - fall_cyc, 68);
    end
    if (!(&cs_n) && bitpos >= 0) miso = sens[cur_ch][bitpos];
    else miso = 1'b0;
    cs_prev   = cs_n;
    sclk_prev = sclk;
  end

  task automatic exp_frame(input int ch, input logic [15:0] w, input int ts);
    exp_q.push_back({1'b0, 4'hA, 4'(ch)});
`ifdef SPI_POLL_AGG_TIMESTAMP_EN
    exp_q.push_back({1'b0, 8'(ts)});
`endif
    exp_q.push_back({1'b0, w[15:8]});
    exp_q.push_back({1'b1, w[7:0]});
  endtask

  task automatic compare_stream(input string tag);
    chk({tag, "_len"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk($sformatf("%s[%0d]", tag, i), got_q[i], exp_q[i]);
    got_q.delete();
    exp_q.delete();
  endtask

  // Called just after a posedge; start is seen at the next edge.
  task automatic pulse_start(input logic [NCH-1:0] m);
    chan_mask = m;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic sweep(input logic [NCH-1:0] m, output int n);
    n = 0;
    pulse_start(m);
    for (int c = 0; c < 400; c++) begin
      if (busy) n++;
      else if (n > 0) break;
      @(posedge clk); #1;
    end
    chk("sweep_done", busy, 0);
  endtask

  task automatic settle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    sens[0] = 16'hBEEF;
    sens[1] = 16'hC3A5;
    sens[2] = 16'h1234;
    sens[3] = 16'h0F81;

    settle(3);
    chk("rst_cs_n", cs_n, 4'hF);
    chk("rst_sclk", sclk, 0);
    chk("rst_busy", busy, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_out_data", out_data, 8'h00);
    chk("rst_overflow", overflow, 0);
    @(negedge clk) rst_n = 1'b1;
    settle(2);
    mon_en = 1'b1;

    // basic sweep of channels 0 and 2
    ever_low = '0;
    sweep(4'b0101, n);
    chk("busy_cycles_0101", n, 140);
    exp_frame(0, sens[0], ts_model);
    exp_frame(2, sens[2], ts_model);
    ts_model++;
    settle(10);
    compare_stream("basic");
    chk("cs_selected_0101", ever_low, 4'b0101);

    // backpressure and overflow
    out_ready = 1'b0;
    ever_low  = '0;
    for (int s = 0; s < 3; s++) begin
      sweep(4'hF, n);
      chk("busy_cycles_F", n, 280);
      if (s < 2) for (int c = 0; c < NCH; c++) exp_frame(c, sens[c], ts_model);
      ts_model++;
      if (s == 1) chk("ovf_at_full", overflow, 0);
    end
    chk("ovf_set", overflow, 1);
    chk("hold_valid", out_valid, 1);
    chk("hold_data", out_data, 8'hA0);
    chk("hold_last", out_last, 0);
    chk("cs_selected_F", ever_low, 4'hF);
    first_acc = -1;
    out_ready = 1'b1;
    settle(50);
    chk("no_bubble", last_acc - first_acc + 1, 8 * NB);
    compare_stream("drain");
    chk("ovf_sticky", overflow, 1);
    clear_ovf = 1'b1;
    settle(1);
    clear_ovf = 1'b0;
    chk("ovf_cleared", overflow, 0);

    // reset in the middle of a shift
    mon_en = 1'b0;
    rises  = 0;
    pulse_start(4'b0001);
    for (int c = 0; c < 100 && rises < 5; c++) settle(1);
    chk("reached_bit5", rises, 5);
    @(negedge clk) rst_n = 1'b0;
    #1;
    chk("mid_rst_cs_n", cs_n, 4'hF);
    chk("mid_rst_sclk", sclk, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_out_valid", out_valid, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    ts_model = 0;
    settle(2);
    got_q.delete();
    mon_en = 1'b1;
    sweep(4'b0001, n);
    chk("busy_cycles_0001", n, 70);
    exp_frame(0, sens[0], ts_model);
    ts_model++;
    settle(10);
    compare_stream("after_reset");

    // ignored starts
    ever_low = '0;
    pulse_start(4'b0000);
    settle(5);
    chk("mask0_busy", busy, 0);
    ena = 1'b0;
    pulse_start(4'hF);
    settle(5);
    chk("ena0_busy", busy, 0);
    ena = 1'b1;
    pulse_start(4'b0001);
    settle(10);
    chk("busy_mid_sweep", busy, 1);
    pulse_start(4'hF);
    for (int c = 0; c < 200 && busy; c++) settle(1);
    chk("busy_done", busy, 0);
    settle(20);
    chk("no_restart", busy, 0);
    exp_frame(0, sens[0], ts_model);
    ts_model++;
    compare_stream("ignored_starts");
    chk("cs_selected_0001", ever_low, 4'b0001);

`ifdef SPI_POLL_AGG_TIMESTAMP_EN
    // sweep stamp from a fresh reset: A0 00 BE EF A0 01 BE EF
    @(negedge clk) rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    settle(2);
    got_q.delete();
    exp_q.delete();
    sweep(4'b0001, n);
    sweep(4'b0001, n);
    exp_q.push_back(9'h0A0); exp_q.push_back(9'h000);
    exp_q.push_back(9'h0BE); exp_q.push_back(9'h1EF);
    exp_q.push_back(9'h0A0); exp_q.push_back(9'h001);
    exp_q.push_back(9'h0BE); exp_q.push_back(9'h1EF);
    settle(10);
    compare_stream("timestamp");
`endif

    chk("cs_onehot", onehot_viol, 0);
    chk("sclk_idle_low", idle_viol, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
